mc_fifo: RTL and testbench

Multi-channel synchronous FIFO: NUM_CH independent queues in one statically partitioned storage array, with one shared write port and one shared read port, each addressed by a channel select. It generalises the single-channel FIFO to per-channel flags, fill counts, parameterised almost-thresholds and per-channel flush. It sits between the port-side ingress logic and the shared cache arbiter, buffering per-port traffic.

---
 rtl/mc_fifo.sv | 139 +++++++++++++
 tb/tb_mc_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_fifo.sv
// Multi-channel synchronous FIFO: NUM_CH queues statically partitioned in one storage array,
// shared write/read ports selected by channel. Define MC_FIFO_ERR_EN for sticky overflow/underflow flags.
module mc_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [CH_W-1:0]                  wr_ch,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             rd_en,
  input  logic [CH_W-1:0]                  rd_ch,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_vld,
  input  logic [NUM_CH-1:0]                flush,
  output logic [NUM_CH-1:0]                full,
  output logic [NUM_CH-1:0]                almost_full,
  output logic [NUM_CH-1:0]                empty,
  output logic [NUM_CH-1:0]                almost_empty,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count
`ifdef MC_FIFO_ERR_EN
  ,
  input  logic                             err_clr,
  output logic [NUM_CH-1:0]                ovf_err,
  output logic [NUM_CH-1:0]                udf_err
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int MW    = CH_W + ADDR_WIDTH;

  logic [PW-1:0]         r_wptr [NUM_CH];
  logic [PW-1:0]         r_rptr [NUM_CH];
  logic [DATA_WIDTH-1:0] r_mem  [NUM_CH*DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;

  logic [PW-1:0]         w_cnt [NUM_CH];
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [MW-1:0]         w_waddr;
  logic [MW-1:0]         w_raddr;

  // Flags and fill levels derive only from registered pointers.
  always_comb begin
    full         = '0;
    almost_full  = '0;
    empty        = '0;
    almost_empty = '0;
    count        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt[c]                 = r_wptr[c] - r_rptr[c];
      full[c]                  = (w_cnt[c] == PW'(DEPTH));
      empty[c]                 = (w_cnt[c] == '0);
      almost_full[c]           = (w_cnt[c] >= PW'(AFULL_LVL));
      almost_empty[c]          = (w_cnt[c] <= PW'(AEMPTY_LVL));
      count[c*PW +: PW]        = w_cnt[c];
    end
  end

  assign w_wr_acc = wr_en && !full[wr_ch] && !flush[wr_ch];
  assign w_rd_acc = rd_en && !empty[rd_ch] && !flush[rd_ch];
  assign w_waddr  = {wr_ch, r_wptr[wr_ch][ADDR_WIDTH-1:0]};
  assign w_raddr  = {rd_ch, r_rptr[rd_ch][ADDR_WIDTH-1:0]};

  // Flush takes priority over any same-cycle write or read on that channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush[c]) begin
          r_wptr[c] <= '0;
          r_rptr[c] <= '0;
        end else begin
          if (w_wr_acc && (wr_ch == CH_W'(c))) r_wptr[c] <= r_wptr[c] + 1'b1;
          if (w_rd_acc && (rd_ch == CH_W'(c))) r_rptr[c] <= r_rptr[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_waddr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[w_raddr];
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

`ifdef MC_FIFO_ERR_EN
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_udf;
  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_udf_set;

  always_comb begin
    w_ovf_set = '0;
    w_udf_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ovf_set[c] = wr_en && (wr_ch == CH_W'(c)) && full[c]  && !flush[c];
      w_udf_set[c] = rd_en && (rd_ch == CH_W'(c)) && empty[c] && !flush[c];
    end
  end

  // A new error in the same cycle as err_clr survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= (err_clr ? '0 : r_ovf) | w_ovf_set;
      r_udf <= (err_clr ? '0 : r_udf) | w_udf_set;
    end
  end

  assign ovf_err = r_ovf;
  assign udf_err = r_udf;
`endif

endmodule

// File: tb/tb_mc_fifo.sv
// Directed self-checking bench for mc_fifo (4 channels, depth 16).
module tb_mc_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [31:0] din = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [31:0] dout;
  logic        dout_vld;
  logic [3:0]  flush = '0;
  logic [3:0]  full, almost_full, empty, almost_empty;
  logic [19:0] count;
`ifdef MC_FIFO_ERR_EN
  logic        err_clr = 1'b0;
  logic [3:0]  ovf_err, udf_err;
`endif

  int errors = 0;
  int checks = 0;

  mc_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .din(din),
    .rd_en(rd_en), .rd_ch(rd_ch), .dout(dout), .dout_vld(dout_vld),
    .flush(flush), .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .count(count)
`ifdef MC_FIFO_ERR_EN
    , .err_clr(err_clr), .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] cnt(input int ch);
    return count[ch*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step(); step();
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL reset_empty got=%h exp=f", empty); end
    checks++; if (almost_empty !== 4'hF) begin errors++; $display("FAIL reset_aempty got=%h exp=f", almost_empty); end
    checks++; if (full !== 4'h0 || almost_full !== 4'h0) begin errors++; $display("FAIL reset_full got=%h/%h exp=0/0", full, almost_full); end
    checks++; if (count !== 20'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", count); end
    checks++; if (dout !== 32'h0 || dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout got=%h/%b exp=0/0", dout, dout_vld); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_ch = 2'd1; din = vals[i];
      step();
      checks++; if (empty[1] !== 1'b0 || cnt(1) !== 5'(i + 1)) begin errors++; $display("FAIL basic_wr%0d empty/count got=%b/%0d exp=0/%0d", i, empty[1], cnt(1), i + 1); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_ch = 2'd1;
      step();
      checks++; if (dout_vld !== 1'b1 || dout !== vals[i]) begin errors++; $display("FAIL basic_rd%0d got=%h vld=%b exp=%h", i, dout, dout_vld, vals[i]); end
      checks++; if (cnt(1) !== 5'(2 - i)) begin errors++; $display("FAIL basic_cnt%0d got=%0d exp=%0d", i, cnt(1), 2 - i); end
    end
    idle();
    step();
    checks++; if (dout_vld !== 1'b0 || dout !== 32'h33) begin errors++; $display("FAIL basic_hold got=%h vld=%b exp=33/0", dout, dout_vld); end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b exp=1", empty[1]); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_ch = 2'd0; din = 32'h100 + 32'(i);
      step();
      checks++; if (almost_full[0] !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull%0d got=%b", i + 1, almost_full[0]); end
      checks++; if (full[0] !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full%0d got=%b", i + 1, full[0]); end
    end
    din = 32'hDEAD;
    step();
    idle();
    checks++; if (cnt(0) !== 5'd16 || full[0] !== 1'b1) begin errors++; $display("FAIL fill_17th count=%0d full=%b exp=16/1", cnt(0), full[0]); end
    checks++; if (empty[3:1] !== 3'b111) begin errors++; $display("FAIL fill_others got=%b exp=111", empty[3:1]); end
`ifdef MC_FIFO_ERR_EN
    checks++; if (ovf_err !== 4'b0001) begin errors++; $display("FAIL fill_ovf got=%b exp=0001", ovf_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (ovf_err !== 4'b0000) begin errors++; $display("FAIL fill_ovf_clr got=%b exp=0000", ovf_err); end
`endif
    for (int j = 0; j < 16; j++) begin
      rd_en = 1'b1; rd_ch = 2'd0;
      step();
      checks++; if (dout_vld !== 1'b1 || dout !== 32'h100 + 32'(j)) begin errors++; $display("FAIL drain%0d got=%h vld=%b exp=%h", j, dout, dout_vld, 32'h100 + 32'(j)); end
      checks++; if (almost_empty[0] !== (15 - j <= 2)) begin errors++; $display("FAIL drain_aempty%0d got=%b", j, almost_empty[0]); end
    end
    idle();
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty[0]); end
  endtask

  task automatic test_interleave();
    logic [31:0] q2 [$];
    logic [31:0] q3 [$];
    for (int i = 0; i < 40; i++) begin
      int wch;
      int rch;
      logic [31:0] wd;
      logic [31:0] exp_d;
      logic exp_v;
      wch = (i % 2 == 0) ? 2 : 3;
      rch = (i % 2 == 0) ? 3 : 2;
      wd = 32'hC000_0000 | 32'(wch << 16) | 32'(i);
      exp_v = 1'b0; exp_d = '0;
      if (rch == 2 && q2.size() > 0) begin exp_v = 1'b1; exp_d = q2.pop_front(); end
      if (rch == 3 && q3.size() > 0) begin exp_v = 1'b1; exp_d = q3.pop_front(); end
      if (wch == 2) q2.push_back(wd); else q3.push_back(wd);
      wr_en = 1'b1; wr_ch = 2'(wch); din = wd;
      rd_en = 1'b1; rd_ch = 2'(rch);
      step();
      checks++; if (dout_vld !== exp_v) begin errors++; $display("FAIL ilv_vld%0d got=%b exp=%b", i, dout_vld, exp_v); end
      if (exp_v) begin
        checks++; if (dout !== exp_d) begin errors++; $display("FAIL ilv_data%0d got=%h exp=%h", i, dout, exp_d); end
      end
    end
    idle();
    checks++; if (cnt(2) !== 5'(q2.size()) || cnt(3) !== 5'(q3.size())) begin errors++; $display("FAIL ilv_counts got=%0d/%0d exp=%0d/%0d", cnt(2), cnt(3), q2.size(), q3.size()); end
    flush = 4'b1100;
    step();
    flush = '0;
    checks++; if (cnt(2) !== 5'd0 || cnt(3) !== 5'd0) begin errors++; $display("FAIL ilv_flush got=%0d/%0d exp=0/0", cnt(2), cnt(3)); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_ch = 2'd2; din = 32'h2A0 + 32'(i);
      step();
    end
    din = 32'hBAD; rd_en = 1'b1; rd_ch = 2'd2;
    step();
    wr_en = 1'b0;
    checks++; if (dout_vld !== 1'b1 || dout !== 32'h2A0) begin errors++; $display("FAIL fullrw_head got=%h vld=%b exp=2a0", dout, dout_vld); end
    checks++; if (cnt(2) !== 5'd15 || full[2] !== 1'b0) begin errors++; $display("FAIL fullrw_count got=%0d full=%b exp=15/0", cnt(2), full[2]); end
    for (int j = 1; j < 16; j++) begin
      step();
      checks++; if (dout !== 32'h2A0 + 32'(j)) begin errors++; $display("FAIL fullrw_drain%0d got=%h exp=%h", j, dout, 32'h2A0 + 32'(j)); end
    end
    idle();
    step();
    checks++; if (empty[2] !== 1'b1 || dout_vld !== 1'b0) begin errors++; $display("FAIL fullrw_end empty=%b vld=%b exp=1/0", empty[2], dout_vld); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_ch = 2'd0; din = 32'h500 + 32'(i);
      step();
    end
    flush = 4'b0001; rd_en = 1'b1; rd_ch = 2'd0; wr_ch = 2'd1; din = 32'h77;
    step();
    idle();
    checks++; if (cnt(0) !== 5'd0 || empty[0] !== 1'b1) begin errors++; $display("FAIL flush_ch0 count=%0d empty=%b exp=0/1", cnt(0), empty[0]); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got=%b exp=0", dout_vld); end
    checks++; if (cnt(1) !== 5'd1) begin errors++; $display("FAIL flush_ch1 got=%0d exp=1", cnt(1)); end
    rd_en = 1'b1; rd_ch = 2'd1;
    step();
    idle();
    checks++; if (dout_vld !== 1'b1 || dout !== 32'h77) begin errors++; $display("FAIL flush_ch1_rd got=%h vld=%b exp=77", dout, dout_vld); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_ch = 2'd3; din = 32'h800 + 32'(i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_ch = 2'd3;
    step();
    checks++; if (dout_vld !== 1'b1 || dout !== 32'h800) begin errors++; $display("FAIL rstmid_pre got=%h vld=%b exp=800", dout, dout_vld); end
    rst = 1'b1;
    #1;
    checks++; if (dout_vld !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL rstmid_dout got=%h vld=%b exp=0/0", dout, dout_vld); end
    checks++; if (count !== 20'h0 || empty !== 4'hF || full !== 4'h0) begin errors++; $display("FAIL rstmid_flags count=%h empty=%h full=%h", count, empty, full); end
    step();
    rst = 1'b0;
    step();
    checks++; if (dout_vld !== 1'b0 || cnt(3) !== 5'd0) begin errors++; $display("FAIL rstmid_rd vld=%b count=%0d exp=0/0", dout_vld, cnt(3)); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_interleave();
    test_full_rw();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
